instr_fetch: RTL and testbench

- Fetch stage of the MIPS datapath. Holds the PC, fetches one instruction at a time over a request/acknowledge instruction-memory port, and presents the instruction and its decoded fields (OPCODE, FUNCT, registers, immediate) to the control unit and register file.
- Consumes the control unit's PC_SRC and JUMP outputs to select the next PC: sequential, branch or jump.
- Only one fetch is outstanding at a time; a held instruction is retired only when downstream is not stalling.

---
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// MIPS fetch stage: PC register, single-outstanding imem request/ack fetch, instruction hold and decode.
// Fetch latency 1 cycle after REQ with zero-wait memory; STALL holds the fetched instruction and all outputs.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             PC_SRC,
  input  logic             JUMP,
  output logic             IMEM_REQ,
  output logic [31:0]      IMEM_ADDR,
  input  logic             IMEM_ACK,
  input  logic [31:0]      IMEM_RDATA,
  output logic             INSTR_VALID,
  output logic [31:0]      INSTR,
  output logic [5:0]       OPCODE,
  output logic [5:0]       FUNCT,
  output logic [4:0]       RS,
  output logic [4:0]       RT,
  output logic [4:0]       RD,
  output logic [15:0]      IMM,
  output logic [31:0]      PC,
  output logic [31:0]      PC_PLUS4,
  output logic [CNT_W-1:0] RETIRE_CNT
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      br_off;
  logic [31:0]      next_pc;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    // JUMP outranks PC_SRC when the control unit raises both
    if (JUMP)        next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    else if (PC_SRC) next_pc = pc_plus4 + br_off;
    else             next_pc = pc_plus4;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (IMEM_ACK) begin
          instr_d = IMEM_RDATA;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && !STALL) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign IMEM_REQ    = (state_q == REQ);
  assign IMEM_ADDR   = pc_q;
  assign INSTR_VALID = valid_q;
  assign INSTR       = instr_q;
  assign OPCODE      = instr_q[31:26];
  assign FUNCT       = instr_q[5:0];
  assign RS          = instr_q[25:21];
  assign RT          = instr_q[20:16];
  assign RD          = instr_q[15:11];
  assign IMM         = instr_q[15:0];
  assign PC          = pc_q;
  assign PC_PLUS4    = pc_plus4;
  assign RETIRE_CNT  = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic against a transaction-level reference model.
module tb_instr_fetch;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL = 1'b0, PC_SRC = 1'b0, JUMP = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        INSTR_VALID;
  logic [31:0] INSTR, PC, PC_PLUS4, RETIRE_CNT;
  logic [5:0]  OPCODE, FUNCT;
  logic [4:0]  RS, RT, RD;
  logic [15:0] IMM;

  int total = 0;
  int bad   = 0;

  // Reference model: what the fetch unit "knows", not how it is encoded
  bit          m_fresh;   // first cycle after reset release, memory ignored
  bit          m_held;    // an unretired instruction is being presented
  logic [31:0] m_pc, m_instr, m_cnt;

  instr_fetch #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .PC_SRC(PC_SRC), .JUMP(JUMP),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .INSTR_VALID(INSTR_VALID), .INSTR(INSTR), .OPCODE(OPCODE), .FUNCT(FUNCT),
    .RS(RS), .RT(RT), .RD(RD), .IMM(IMM), .PC(PC), .PC_PLUS4(PC_PLUS4), .RETIRE_CNT(RETIRE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] target(input logic [31:0] pc, input logic [31:0] ins,
                                         input bit jmp, input bit br);
    longint seq, off;
    seq = (longint'(pc) + 4) % 64'h1_0000_0000;
    if (jmp) return ((seq / 32'h1000_0000) * 32'h1000_0000) + (ins % 32'h0400_0000) * 4;
    if (br) begin
      off = (ins % 65536);
      if (off >= 32768) off = off - 65536;
      return 32'((seq + off * 4 + 64'h1_0000_0000) % 64'h1_0000_0000);
    end
    return 32'(seq);
  endfunction

  task automatic model_reset();
    m_fresh = 1; m_held = 0; m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic check_outputs();
    chk("req",    {31'b0, IMEM_REQ},    {31'b0, !m_fresh && !m_held});
    chk("addr",   IMEM_ADDR,            m_pc);
    chk("valid",  {31'b0, INSTR_VALID}, {31'b0, m_held});
    chk("instr",  INSTR,                m_instr);
    chk("opcode", {26'b0, OPCODE},      m_instr / 32'h0400_0000);
    chk("funct",  {26'b0, FUNCT},       m_instr % 64);
    chk("rs",     {27'b0, RS},          (m_instr / 32'h20_0000) % 32);
    chk("rt",     {27'b0, RT},          (m_instr / 32'h1_0000) % 32);
    chk("rd",     {27'b0, RD},          (m_instr / 32'h800) % 32);
    chk("imm",    {16'b0, IMM},         m_instr % 65536);
    chk("pc",     PC,                   m_pc);
    chk("pc4",    PC_PLUS4,             m_pc + 32'd4);
    chk("cnt",    RETIRE_CNT,           m_cnt);
  endtask

  // One clock: check, drive, advance model, move to just after the next falling edge
  task automatic cycle(input bit ack, input bit stall, input bit br, input bit jmp, input logic [31:0] rdata);
    check_outputs();
    IMEM_ACK = ack; STALL = stall; PC_SRC = br; JUMP = jmp; IMEM_RDATA = rdata;
    if (m_fresh) m_fresh = 0;
    else if (!m_held) begin
      if (ack) begin m_held = 1; m_instr = rdata; end
    end else if (!stall) begin
      m_pc = target(m_pc, m_instr, jmp, br);
      m_held = 0;
      m_cnt = m_cnt + 1;
    end
    @(negedge CLK); #1;
  endtask

  // Fetch one word at the current PC then retire it with the given control
  task automatic fetch_retire(input logic [31:0] word, input bit br, input bit jmp);
    cycle(1, 0, 0, 0, word);
    cycle(0, 0, br, jmp, 32'h0);
  endtask

  initial begin
    int n;
    model_reset();
    #3;
    check_outputs();
    @(negedge CLK); #1;
    check_outputs();
    RST = 0;

    // zero-wait streaming; memory returns a word derived from the address
    cycle(1, 0, 0, 0, 32'h0);                       // idle cycle, ack ignored
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", IMEM_ADDR, 32'(i * 4));
      fetch_retire(32'h2000_0000 + 32'(i), 0, 0);
    end
    chk("cnt3", RETIRE_CNT, 32'd3);
    fetch_retire(32'h0000_0020, 0, 0);              // PC now 0x10

    // three wait states at 0x10
    for (int i = 0; i < 3; i++) cycle(0, $urandom_range(0, 1), 1, 1, $urandom);
    cycle(1, 0, 0, 0, 32'h0123_4567);
    chk("late_instr", INSTR, 32'h0123_4567);
    cycle(0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) fetch_retire(32'h0000_0020, 0, 0);
    chk("at20", IMEM_ADDR, 32'h20);

    // beq -1 at 0x20, held through a 4-cycle stall first
    cycle(1, 0, 0, 0, 32'h1000_FFFF);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 1, 32'h0);
    chk("stall_cnt", RETIRE_CNT, 32'd8);
    cycle(0, 0, 1, 0, 32'h0);
    chk("beq_taken", IMEM_ADDR, 32'h20);
    fetch_retire(32'h1000_FFFF, 0, 0);
    chk("beq_not", IMEM_ADDR, 32'h24);
    fetch_retire(32'h0800_0040, 1, 1);
    chk("jump_prio", IMEM_ADDR, 32'h100);

    // random traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
            $urandom_range(0, 1), $urandom_range(0, 99) < 20, $urandom);

    // reset while a request is pending with a stray ack
    n = 0;
    while ((m_fresh || m_held) && n < 8) begin cycle(0, 0, 0, 0, 32'h0); n++; end
    chk("req_reached", {31'b0, IMEM_REQ}, 32'd1);
    IMEM_ACK = 1; IMEM_RDATA = 32'hDEAD_BEEF;
    #2 RST = 1;
    #1;
    model_reset();
    check_outputs();
    @(negedge CLK); #1;
    check_outputs();
    RST = 0;
    cycle(1, 0, 0, 0, 32'hDEAD_BEEF);               // post-reset idle ignores the ack
    chk("restart_addr", IMEM_ADDR, 32'h0);
    for (int i = 0; i < 40; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, 99) < 25, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
